level_meter: RTL and testbench
==============================

Name: level_meter

Overview:
Envelope/peak stage directly upstream of the LED bar-graph driver. Accepts 12-bit ADC samples on the 44100 Hz dclk domain and folds each sample about mid-scale into an 11-bit magnitude. Holds the peak magnitude over a fixed window of 512 accepted samples, about 86 Hz. Once per window it publishes the top 6 bits of that peak as the level word consumed by the bar-graph driver.

Parameters:
DATA_W, 12, ADC sample width; mid-scale = 2^(DATA_W-1).
WIN_LOG2, 9, log2 of window length in accepted samples (512).
OUT_W, 6, level output width; taken from the MSBs of the magnitude.
DECAY_STEP, 1, per-window level decrement; used only with the optional feature.

Ports:
dclk  input  1  sample clock, 44100 Hz.
rst  input  1  asynchronous reset, active-high.
sample_valid  input  1  sample strobe; sample accepted on the dclk rising edge when high.
sample  input  DATA_W  unsigned offset-binary ADC sample.
level  output  OUT_W  registered peak level for the last completed window.
level_update  output  1  single-cycle pulse, high in the cycle level takes a new value.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock dclk. All state is updated on the dclk rising edge only.
- Reset values: level = 0, level_update = 0, peak register = 0, window counter = 0, state = IDLE.
- Magnitude fold, combinational, DATA_W-1 bits:
  - sample >= 2048: mag = sample - 2048.
  - sample < 2048: mag = 2047 - sample.
  - Range 0..2047. Both 0 and 4095 map to 2047. 2047 and 2048 both map to 0.
- Level extraction: level_new = pk[DATA_W-2 -: OUT_W], i.e. bits 10:5 for the defaults.
- State machine:
  - IDLE: nothing accepted since reset. The first accepted sample moves to ACCUM with peak = mag and count = 1.
  - ACCUM: each accepted sample sets peak = max(peak, mag) and count = count + 1.
  - Window end: on the accepted sample where count == 2^WIN_LOG2 - 1:
    - pk = max(peak, mag), so the 512th sample is included in this window.
    - level <= level_new(pk) and level_update <= 1, both visible the cycle after the accepting edge.
    - peak <= 0 and count <= 0. State stays ACCUM.
- level_update: high for exactly one dclk cycle per window, otherwise 0. level is stable between pulses.
- sample_valid low: no state change; level holds and level_update is 0 after any pending pulse. Gaps between samples of any length are permitted and do not count toward the window.
- Counter: WIN_LOG2 bits, wraps from 511 to 0 at window end. The window length is exactly 512 accepted samples, independent of idle cycles.
- Reset mid-window: the partial window is discarded and level returns to 0 immediately (asynchronously). The next window starts from the first sample accepted after reset deassertion.
- Back-to-back windows: a sample accepted in the cycle after a window end is the first sample of the next window. No samples are dropped.

Optional Feature:
LEVEL_DECAY_EN
- Defined: at window end, level <= max(level_new, level - DECAY_STEP), saturating at 0. Rises are immediate; falls step down by at most DECAY_STEP per window, giving a ballistic meter fall.
- Undefined: level <= level_new unconditionally.
- level_update timing and all other behaviour are identical in both builds.

Test Plan:
1. Assert rst mid-stream with sample_valid high -> level = 0 and level_update = 0 immediately. Exactly 512 further accepted samples -> one level_update pulse.
2. 512 samples of 2048, no gaps -> level_update pulses once, the cycle after the 512th accept; level = 0.
3. 511 samples of 2048 plus one sample of 4095 at position 300 -> level = 63. Next window of all 2048 -> level = 0 (decay undefined).
4. Window containing one sample of 0 -> level = 63. Window with peak sample 1024 (mag 1023) -> level = 31. Window with peak sample 2080 (mag 32) -> level = 1.
5. 512 valid samples interleaved with 1-7 idle cycles each -> exactly one level_update. The 513th sample starts a new window: its pulse arrives after 512 more samples.
6. LEVEL_DECAY_EN defined: window 1 peak 4095 (level 63), then three windows of 2048 -> level 62, 61, 60. Undefined build: 63, 0, 0, 0.

Source files
------------

// File: rtl/level_meter_if.sv
// level_meter_if: sample stream in, peak level word and update strobe out.
interface level_meter_if #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 6
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [OUT_W-1:0]  level;
  logic              level_update;
  modport master (output sample_valid, sample, input level, level_update);
  modport slave  (input sample_valid, sample, output level, level_update);
endinterface

// File: rtl/level_meter.sv
// level_meter: folds ADC samples into magnitudes and publishes the per-window peak level.
// Optional LEVEL_DECAY_EN: level falls by at most DECAY_STEP per window.
module level_meter #(
  parameter int DATA_W     = 12,
  parameter int WIN_LOG2   = 9,
  parameter int OUT_W      = 6,
  parameter int DECAY_STEP = 1
) (
  input logic           dclk,
  input logic           rst,
  level_meter_if.slave  bus
);
`ifdef LEVEL_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif
  localparam logic [OUT_W-1:0] STEP = OUT_W'(DECAY_STEP);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-2:0]   peak_q, peak_d, mag, pk;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]    level_q, level_d, level_new, level_dec, level_calc;
  logic                upd_q, upd_d, win_end;
  // Below mid-scale the distance to mid is the ones' complement of the low bits.
  assign mag        = bus.sample[DATA_W-1] ? bus.sample[DATA_W-2:0] : ~bus.sample[DATA_W-2:0];
  assign pk         = (mag > peak_q) ? mag : peak_q;
  assign level_new  = pk[DATA_W-2 -: OUT_W];
  assign level_dec  = (level_q > STEP) ? level_q - STEP : '0;
  assign level_calc = (DECAY_ON && level_dec > level_new) ? level_dec : level_new;
  assign win_end    = bus.sample_valid && (cnt_q == {WIN_LOG2{1'b1}});
  always_comb begin
    state_d = bus.sample_valid ? ACCUM : state_q;
    cnt_d   = bus.sample_valid ? cnt_q + 1'b1 : cnt_q;
    peak_d  = !bus.sample_valid ? peak_q : (win_end ? '0 : pk);
    level_d = win_end ? level_calc : level_q;
    upd_d   = win_end;
  end
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
      level_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      level_q <= level_d;
      upd_q   <= upd_d;
    end
  end
  assign bus.level        = level_q;
  assign bus.level_update = upd_q;
endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: random and directed windows checked against a window-max reference model.
module tb_level_meter;
  logic dclk = 1'b0;
  logic rst  = 1'b1;
  int n_cmp = 0, n_bad = 0;
  int pulses = 0, seq_err = 0;
  int exp_level = 0, win_max = 0, win_n = 0;
  logic exp_pulse = 1'b0;
  level_meter_if #(.DATA_W(12), .OUT_W(6)) bus ();
  level_meter #(.DATA_W(12), .WIN_LOG2(9), .OUT_W(6), .DECAY_STEP(1)) dut (
    .dclk(dclk), .rst(rst), .bus(bus)
  );
  always #5 dclk = ~dclk;

  function automatic int magnitude(input int s);
    return (s >= 2048) ? s - 2048 : 2047 - s;
  endfunction

  function automatic int next_level(input int peak, input int prev);
    int nl;
    nl = peak / 32;
`ifdef LEVEL_DECAY_EN
    if (prev - 1 > nl) nl = prev - 1;
`endif
    return nl;
  endfunction

  task automatic model_reset();
    exp_level = 0; exp_pulse = 1'b0; win_max = 0; win_n = 0;
  endtask

  // One cycle: record observations of the previous edge, then drive and advance the model.
  task automatic drive(input logic v, input int s);
    @(negedge dclk);
    if (bus.level_update !== exp_pulse || bus.level !== 6'(exp_level)) begin
      seq_err++;
      if (seq_err < 4)
        $display("observe t=%0t update=%b/%b level=%0d/%0d", $time, bus.level_update, exp_pulse, bus.level, exp_level);
    end
    if (bus.level_update === 1'b1) pulses++;
    bus.sample_valid = v;
    bus.sample = 12'(s);
    exp_pulse = 1'b0;
    if (v) begin
      if (magnitude(s) > win_max) win_max = magnitude(s);
      win_n++;
      if (win_n == 512) begin
        exp_level = next_level(win_max, exp_level);
        exp_pulse = 1'b1;
        win_n = 0;
        win_max = 0;
      end
    end
  endtask

  task automatic window(input int fill, input int pos, input int special);
    for (int i = 0; i < 512; i++) drive(1'b1, (i == pos) ? special : fill);
    drive(1'b0, 0);
  endtask

  task automatic check_seq(input string name);
    n_cmp++;
    if (seq_err != 0) begin
      n_bad++;
      $display("FAIL %s: %0d cycle(s) differ in level/level_update, want 0", name, seq_err);
    end
    seq_err = 0;
  endtask

  task automatic test_reset();
    int p0;
    n_cmp++;
    if (bus.level !== 6'd0 || bus.level_update !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init: level=%0d update=%b want 0/0", bus.level, bus.level_update);
    end
    @(negedge dclk); rst = 1'b0;
    window(2048, 10, 0);
    for (int i = 0; i < 200; i++) drive(1'b1, $urandom_range(0, 4095));
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.level !== 6'd0 || bus.level_update !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: level=%0d update=%b want 0/0", bus.level, bus.level_update);
    end
    model_reset();
    @(negedge dclk); bus.sample_valid = 1'b0; rst = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 512; i++) drive(1'b1, $urandom_range(0, 4095));
    drive(1'b0, 0); drive(1'b0, 0);
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL reset_window_pulses: got %0d want 1", pulses - p0);
    end
    check_seq("reset_seq");
  endtask

  task automatic test_silence();
    int p0;
    p0 = pulses;
    window(2048, 0, 2048);
    n_cmp++;
    if (pulses - p0 !== 1 || bus.level !== 6'd0) begin
      n_bad++;
      $display("FAIL silence: pulses=%0d level=%0d want 1/0", pulses - p0, bus.level);
    end
    check_seq("silence_seq");
  endtask

  task automatic test_boundaries();
    int specials[5] = '{4095, 0, 1024, 2080, 2047};
    int want[5]     = '{63, 63, 31, 1, 0};
    for (int k = 0; k < 5; k++) begin
      window(2048, (k == 0) ? 300 : $urandom_range(0, 511), specials[k]);
      n_cmp++;
      if (bus.level !== 6'(exp_level)) begin
        n_bad++;
        $display("FAIL boundary_%0d: level=%0d want %0d", specials[k], bus.level, exp_level);
      end
`ifndef LEVEL_DECAY_EN
      n_cmp++;
      if (bus.level !== 6'(want[k])) begin
        n_bad++;
        $display("FAIL boundary_const_%0d: level=%0d want %0d", specials[k], bus.level, want[k]);
      end
`endif
    end
    check_seq("boundary_seq");
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, $urandom_range(0, 4095));
      repeat ($urandom_range(1, 7)) drive(1'b0, $urandom_range(0, 4095));
    end
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL gaps_pulses: got %0d want 1", pulses - p0);
    end
    p0 = pulses;
    for (int i = 0; i < 511; i++) begin
      drive(1'b1, $urandom_range(0, 4095));
      if (($urandom & 3) == 0) drive(1'b0, 0);
    end
    drive(1'b0, 0);
    n_cmp++;
    if (pulses - p0 !== 0) begin
      n_bad++;
      $display("FAIL gaps_early: got %0d pulses want 0", pulses - p0);
    end
    drive(1'b1, $urandom_range(0, 4095));
    drive(1'b0, 0);
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL gaps_second: got %0d pulses want 1", pulses - p0);
    end
    check_seq("gaps_seq");
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 3 * 512; i++) drive(1'b1, $urandom_range(1024, 3071));
    drive(1'b0, 0);
    n_cmp++;
    if (pulses - p0 !== 3 || bus.level !== 6'(exp_level)) begin
      n_bad++;
      $display("FAIL back_to_back: pulses=%0d level=%0d want 3/%0d", pulses - p0, bus.level, exp_level);
    end
    check_seq("back_to_back_seq");
  endtask

  task automatic test_decay();
`ifdef LEVEL_DECAY_EN
    int want[4] = '{63, 62, 61, 60};
`else
    int want[4] = '{63, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      window(2048, 100, (k == 0) ? 4095 : 2048);
      n_cmp++;
      if (bus.level !== 6'(want[k])) begin
        n_bad++;
        $display("FAIL decay_%0d: level=%0d want %0d", k, bus.level, want[k]);
      end
    end
    check_seq("decay_seq");
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    repeat (3) @(negedge dclk);
    test_reset();
    test_silence();
    test_boundaries();
    test_gaps();
    test_back_to_back();
    test_decay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
